// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter time-sharing one Baugh-Wooley signed multiplier among p_num_req requesters.
// Optional macro MUL_SHARE_OVERLAP_EN: grant the next request in the response-accept cycle.

module baugh_wooley #(
  parameter int p_width = 8
) (
  input  logic [p_width-1:0]   a_i,
  input  logic [p_width-1:0]   b_i,
  output logic [2*p_width-1:0] product_o
);
  localparam int lp_pw = 2 * p_width;

  logic [lp_pw-1:0] acc;
  logic             pp;

  // Partial products touching exactly one sign bit are inverted; the two
  // correction constants fold the sign weights back in, modulo 2^(2*p_width).
  always_comb begin
    acc = (lp_pw'(1) << p_width) + (lp_pw'(1) << (lp_pw - 1));
    pp  = 1'b0;
    for (int i = 0; i < p_width; i++) begin
      for (int j = 0; j < p_width; j++) begin
        pp = a_i[i] & b_i[j];
        if ((i == p_width - 1) != (j == p_width - 1)) pp = ~pp;
        acc = acc + (lp_pw'(pp) << (i + j));
      end
    end
  end

  assign product_o = acc;
endmodule

// state | meaning
// IDLE  | waiting for any requester; grant combinationally from rr_q
// CALC  | operands in a_q/b_q, multiplier output captured into prod_q
// RESP  | product presented until resp_ready_i
module mul_share_arbiter #(
  parameter int p_width   = 8,
  parameter int p_num_req = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [p_num_req-1:0]           req_valid_i,
  output logic [p_num_req-1:0]           req_ready_o,
  input  logic [p_num_req*p_width-1:0]   req_a_i,
  input  logic [p_num_req*p_width-1:0]   req_b_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic [$clog2(p_num_req)-1:0]   resp_id_o,
  output logic [2*p_width-1:0]           resp_product_o
);
  localparam int lp_id_w = $clog2(p_num_req);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e               state_q;
  logic [lp_id_w-1:0]   rr_q, id_q, next_ptr, base_ptr, grant_id, idx_v;
  logic [p_width-1:0]   a_q, b_q, a_sel, b_sel;
  logic [2*p_width-1:0] prod_q, mult_out;
  logic                 resp_valid_q, grant_any, take_en;
  int                   idx;

  assign next_ptr = (id_q == lp_id_w'(p_num_req - 1)) ? '0 : id_q + 1'b1;

`ifdef MUL_SHARE_OVERLAP_EN
  assign base_ptr = (state_q == RESP) ? next_ptr : rr_q;
  assign take_en  = !reset_i && ((state_q == IDLE) || (state_q == RESP && resp_ready_i));
`else
  assign base_ptr = rr_q;
  assign take_en  = !reset_i && (state_q == IDLE);
`endif

  // Scan from base_ptr upward with explicit wrap so non-power-of-2 counts work.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    idx_v     = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int k = 0; k < p_num_req; k++) begin
      idx = int'(base_ptr) + k;
      if (idx >= p_num_req) idx = idx - p_num_req;
      idx_v = lp_id_w'(idx);
      if (!grant_any && req_valid_i[idx_v]) begin
        grant_any = 1'b1;
        grant_id  = idx_v;
      end
    end
    for (int k = 0; k < p_num_req; k++) begin
      if (grant_id == lp_id_w'(k)) begin
        a_sel = req_a_i[k*p_width +: p_width];
        b_sel = req_b_i[k*p_width +: p_width];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (take_en && grant_any) req_ready_o[grant_id] = 1'b1;
  end

  baugh_wooley #(.p_width(p_width)) u_mul (
    .a_i       (a_q),
    .b_i       (b_q),
    .product_o (mult_out)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      prod_q       <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            a_q     <= a_sel;
            b_q     <= b_sel;
            id_q    <= grant_id;
            state_q <= CALC;
          end
        end
        CALC: begin
          prod_q       <= mult_out;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            rr_q         <= next_ptr;
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
`ifdef MUL_SHARE_OVERLAP_EN
            if (grant_any) begin
              a_q     <= a_sel;
              b_q     <= b_sel;
              id_q    <= grant_id;
              state_q <= CALC;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_id_o      = id_q;
  assign resp_product_o = prod_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: vector table, corner sequences and a randomized exhaustive 4-bit sweep.
// Three instances: 8-bit x4, 8-bit x3 (pointer wrap), 4-bit x4 (exhaustive).
module tb_mul_share_arbiter;
`ifdef MUL_SHARE_OVERLAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 8-bit, 4 requesters
  logic        rst8, rv8, rr8;
  logic [3:0]  v8, rdy8;
  logic [31:0] a8, b8;
  logic [1:0]  id8;
  logic [15:0] p8;
  logic signed [7:0] op_a8 [4];
  logic signed [7:0] op_b8 [4];

  always_comb begin
    a8 = '0;
    b8 = '0;
    for (int k = 0; k < 4; k++) begin
      a8[k*8 +: 8] = op_a8[k];
      b8[k*8 +: 8] = op_b8[k];
    end
  end

  mul_share_arbiter #(.p_width(8), .p_num_req(4)) u8 (
    .clk_i(clk), .reset_i(rst8), .req_valid_i(v8), .req_ready_o(rdy8),
    .req_a_i(a8), .req_b_i(b8), .resp_valid_o(rv8), .resp_ready_i(rr8),
    .resp_id_o(id8), .resp_product_o(p8));

  // 8-bit, 3 requesters
  logic        rst3, rv3, rr3;
  logic [2:0]  v3, rdy3;
  logic [23:0] a3, b3;
  logic [1:0]  id3;
  logic [15:0] p3;

  mul_share_arbiter #(.p_width(8), .p_num_req(3)) u3 (
    .clk_i(clk), .reset_i(rst3), .req_valid_i(v3), .req_ready_o(rdy3),
    .req_a_i(a3), .req_b_i(b3), .resp_valid_o(rv3), .resp_ready_i(rr3),
    .resp_id_o(id3), .resp_product_o(p3));

  // 4-bit, 4 requesters
  logic        rst4, rv4, rr4;
  logic [3:0]  v4, rdy4;
  logic [15:0] a4, b4;
  logic [1:0]  id4;
  logic [7:0]  p4;

  mul_share_arbiter #(.p_width(4), .p_num_req(4)) u4 (
    .clk_i(clk), .reset_i(rst4), .req_valid_i(v4), .req_ready_o(rdy4),
    .req_a_i(a4), .req_b_i(b4), .resp_valid_o(rv4), .resp_ready_i(rr4),
    .resp_id_o(id4), .resp_product_o(p4));

  typedef struct {
    logic [3:0]        mask;
    int                id;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic [15:0]       prod;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on u8 from IDLE, consumed immediately; ends back in IDLE.
  task automatic txn8(input logic [3:0] mask, input int exp_id, input logic [15:0] exp_p,
                      input string nm);
    logic [3:0] oh;
    oh  = 4'b0001 << exp_id;
    rr8 = 1'b1;
    v8  = mask;
    #1;
    chk({nm, "_ready"}, 32'(rdy8), 32'(oh));
    step();
    v8 = '0;
    chk({nm, "_calc_valid"}, 32'(rv8), 32'd0);
    step();
    chk({nm, "_valid"}, 32'(rv8), 32'd1);
    chk({nm, "_id"}, 32'(id8), 32'(exp_id));
    chk({nm, "_prod"}, 32'(p8), 32'(exp_p));
    step();
  endtask

  task automatic txn3(input logic [2:0] mask, input int exp_id, input string nm);
    logic [2:0] oh;
    int         ex;
    oh  = 3'b001 << exp_id;
    ex  = (exp_id + 1) * -5;
    rr3 = 1'b1;
    v3  = mask;
    #1;
    chk({nm, "_ready"}, 32'(rdy3), 32'(oh));
    step();
    v3 = '0;
    step();
    chk({nm, "_valid"}, 32'(rv3), 32'd1);
    chk({nm, "_id"}, 32'(id3), 32'(exp_id));
    chk({nm, "_prod"}, 32'(p3), 32'(ex[15:0]));
    step();
  endtask

  initial begin
    int               ex, g, ptr, d, n, last;
    logic [3:0]       m, oh;
    logic signed [3:0] ai, bi;
    logic [15:0]      hold_p;

    tbl[0] = '{mask: 4'b0100, id: 2, a: -8'sd128, b: -8'sd128, prod: 16'h4000};
    tbl[1] = '{mask: 4'b0100, id: 2, a:  8'sd127, b: -8'sd128, prod: 16'hC080};
    tbl[2] = '{mask: 4'b0100, id: 2, a:  -8'sd1,  b:  -8'sd1,  prod: 16'h0001};
    tbl[3] = '{mask: 4'b0100, id: 2, a:   8'sd0,  b: -8'sd77,  prod: 16'h0000};
    tbl[4] = '{mask: 4'b0001, id: 0, a:   8'sd5,  b:  -8'sd3,  prod: 16'hFFF1};
    tbl[5] = '{mask: 4'b1000, id: 3, a: -8'sd128, b:  8'sd127, prod: 16'hC080};

    for (int k = 0; k < 4; k++) begin
      op_a8[k] = '0;
      op_b8[k] = '0;
    end
    rst8 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    v8 = 4'hF; v3 = '0; v4 = '0;
    rr8 = 1'b0; rr3 = 1'b0; rr4 = 1'b0;
    a3 = '0; b3 = '0; a4 = '0; b4 = '0;
    step();
    step();
    chk("reset_ready_blocked", 32'(rdy8), 32'd0);
    v8 = '0;
    rst8 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
    #1;
    chk("reset_valid", 32'(rv8), 32'd0);
    chk("reset_id", 32'(id8), 32'd0);
    chk("reset_prod", 32'(p8), 32'd0);
    step();

    // Vector table: single requests, signs and extremes.
    for (int t = 0; t < 6; t++) begin
      op_a8[tbl[t].id] = tbl[t].a;
      op_b8[tbl[t].id] = tbl[t].b;
      txn8(tbl[t].mask, tbl[t].id, tbl[t].prod, $sformatf("tbl%0d", t));
    end

    // Backpressure: requester 1 stalled in RESP for 5 cycles while others wait.
    op_a8[1] = -8'sd37; op_b8[1] = 8'sd91;
    ex = -37 * 91;
    rr8 = 1'b0;
    v8  = 4'b0010;
    step();
    v8 = 4'b1101;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(rv8), 32'd1);
      chk("bp_id", 32'(id8), 32'd1);
      chk("bp_prod", 32'(p8), 32'(ex[15:0]));
      chk("bp_ready", 32'(rdy8), 32'd0);
      step();
    end
    v8  = '0;
    rr8 = 1'b1;
    #1;
    chk("bp_release_valid", 32'(rv8), 32'd1);
    step();
    chk("bp_after_valid", 32'(rv8), 32'd0);
    v8 = 4'b0001;
    #1;
    chk("bp_idle_grant", 32'(rdy8), 32'd1);
    v8 = '0;
    step();

    // Reset while in CALC drops the in-flight request.
    op_a8[3] = 8'sd9; op_b8[3] = 8'sd9;
    v8 = 4'b1000;
    step();
    v8   = '0;
    rst8 = 1'b1;
    step();
    chk("rst_mid_valid", 32'(rv8), 32'd0);
    chk("rst_mid_id", 32'(id8), 32'd0);
    chk("rst_mid_prod", 32'(p8), 32'd0);
    chk("rst_mid_ready", 32'(rdy8), 32'd0);
    rst8 = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (rv8) n++;
      step();
    end
    chk("rst_mid_no_resp", 32'(n), 32'd0);
    op_a8[1] = 8'sd12; op_b8[1] = -8'sd11;
    txn8(4'b0010, 1, 16'hFF7C, "rst_next");

    // Round-robin fairness with all four requesters held valid.
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      op_a8[k] = 8'(10 * k + 3);
      op_b8[k] = 8'(-(k + 2));
    end
    rr8 = 1'b1;
    v8  = 4'hF;
    n = 0;
    last = -1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      step();
      if (rv8) begin
        ex = (10 * (n % 4) + 3) * -((n % 4) + 2);
        chk("rr_id", 32'(id8), 32'(n % 4));
        chk("rr_prod", 32'(p8), 32'(ex[15:0]));
        if (last >= 0) chk("rr_gap", 32'(c - last), 32'(GAP));
        last = c;
        n++;
      end
    end
    v8 = '0;
    chk("rr_count", 32'(n), 32'd6);
    step();
    step();

    // Pointer wrap with three requesters.
    for (int k = 0; k < 3; k++) begin
      a3[k*8 +: 8] = 8'(k + 1);
      b3[k*8 +: 8] = 8'hFB;
    end
    txn3(3'b100, 2, "wrap_a");
    txn3(3'b101, 0, "wrap_b");
    txn3(3'b101, 2, "wrap_c");

    // Exhaustive 4-bit products with random requester masks and response stalls.
    ptr = 0;
    for (int pr = 0; pr < 256; pr++) begin
      ai = 4'(pr >> 4);
      bi = 4'(pr);
      m  = 4'($urandom_range(1, 15));
      g  = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && m[(ptr + k) % 4]) g = (ptr + k) % 4;
      for (int k = 0; k < 4; k++) begin
        a4[4*k +: 4] = 4'($urandom);
        b4[4*k +: 4] = 4'($urandom);
      end
      a4[4*g +: 4] = ai;
      b4[4*g +: 4] = bi;
      ex = int'(ai) * int'(bi);
      oh = 4'b0001 << g;
      rr4 = 1'b0;
      v4  = m;
      #1;
      chk("ex_ready", 32'(rdy4), 32'(oh));
      step();
      v4 = '0;
      step();
      chk("ex_valid", 32'(rv4), 32'd1);
      chk("ex_id", 32'(id4), 32'(g));
      chk("ex_prod", 32'(p4), 32'(ex[7:0]));
      hold_p = {8'h00, p4};
      d = $urandom_range(0, 2);
      repeat (d) step();
      chk("ex_hold", 32'({rv4, p4}), 32'({1'b1, hold_p[7:0]}));
      rr4 = 1'b1;
      step();
      rr4 = 1'b0;
      ptr = (g + 1) % 4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
